// File: rtl/l2_port_arbiter_pkg.sv
// Shared types and default widths for the L2 port arbiter slice.
package l2_port_arbiter_pkg;

    localparam int unsigned L2_LINE_W = 256;
    localparam int unsigned L2_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_t;

    typedef enum logic {
        SRC_INST,
        SRC_DATA
    } arb_src_t;

endpackage

// File: rtl/l2_port_arbiter_if.sv
// L1-side (I/D miss paths) and L2-side signals of the shared port.
// slave: the arbiter's view; master: the surrounding caches / L2 model.
interface l2_port_arbiter_if
    import l2_port_arbiter_pkg::*;
#(
    parameter int unsigned LINE_W = L2_LINE_W,
    parameter int unsigned ADDR_W = L2_ADDR_W
);
    logic              inst_read;
    logic [ADDR_W-1:0] inst_address;
    logic              inst_resp;
    logic [LINE_W-1:0] inst_rdata;

    logic              data_read;
    logic              data_write;
    logic [ADDR_W-1:0] data_address;
    logic [LINE_W-1:0] data_wdata;
    logic              data_resp;
    logic [LINE_W-1:0] data_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata256;
    logic              mem_resp;
    logic [LINE_W-1:0] mem_rdata;

    modport slave (
        input  inst_read, inst_address,
        output inst_resp, inst_rdata,
        input  data_read, data_write, data_address, data_wdata,
        output data_resp, data_rdata,
        output mem_read, mem_write, mem_address, mem_wdata256,
        input  mem_resp, mem_rdata
    );

    modport master (
        output inst_read, inst_address,
        input  inst_resp, inst_rdata,
        output data_read, data_write, data_address, data_wdata,
        input  data_resp, data_rdata,
        input  mem_read, mem_write, mem_address, mem_wdata256,
        output mem_resp, mem_rdata
    );

endinterface

// File: rtl/l2_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant between I-side and D-side requests.
module rr_arbiter2
    import l2_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic req_d,
    input  logic advance,
    output logic gnt_i,
    output logic gnt_d
);

    arb_src_t last_grant_q;
    arb_src_t last_grant_d;

    // Grant the side that was not served last when both request.
    always_comb begin
        gnt_i        = req_i && (!req_d || (last_grant_q == SRC_DATA));
        gnt_d        = req_d && !gnt_i;
        last_grant_d = last_grant_q;
        if (advance && gnt_i) begin
            last_grant_d = SRC_INST;
        end else if (advance && gnt_d) begin
            last_grant_d = SRC_DATA;
        end
    end

    // Remember who was granted; reset favours the I-side on first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= SRC_DATA;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares the L2 L1-side port between I-cache and D-cache miss paths.
// The granted request is latched into a command register bank that
// drives the L2 until mem_resp; the response is steered to its owner.
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int unsigned LINE_W = L2_LINE_W,
    parameter int unsigned ADDR_W = L2_ADDR_W
)(
    input logic              clk,
    input logic              rst,
    l2_port_arbiter_if.slave bus
);

    arb_state_t        state_q, state_d;
    logic              cmd_read_q, cmd_read_d;
    logic              cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [LINE_W-1:0] cmd_wdata_q, cmd_wdata_d;

    logic req_i, req_d, gnt_i, gnt_d, advance;
    logic inst_resp_c, data_resp_c;

    assign req_i   = bus.inst_read;
    assign req_d   = bus.data_read | bus.data_write;
    assign advance = (state_q == IDLE);

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_i),
        .req_d   (req_d),
        .advance (advance),
        .gnt_i   (gnt_i),
        .gnt_d   (gnt_d)
    );

    // Next state, command capture on grant, response steering on mem_resp.
    always_comb begin
        state_d     = state_q;
        cmd_read_d  = cmd_read_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        inst_resp_c = 1'b0;
        data_resp_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_i) begin
                    state_d     = BUSY_I;
                    cmd_read_d  = 1'b1;
                    cmd_write_d = 1'b0;
                    cmd_addr_d  = bus.inst_address;
                    cmd_wdata_d = '0;
                end else if (gnt_d) begin
                    // Read+write together is serviced as a writeback.
                    state_d     = BUSY_D;
                    cmd_read_d  = !bus.data_write;
                    cmd_write_d = bus.data_write;
                    cmd_addr_d  = bus.data_address;
                    cmd_wdata_d = bus.data_write ? bus.data_wdata : '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_resp) begin
                    inst_resp_c = (state_q == BUSY_I);
                    data_resp_c = (state_q == BUSY_D);
                    state_d     = IDLE;
                    // Clearing the bank drops the L2 request on the next cycle.
                    cmd_read_d  = 1'b0;
                    cmd_write_d = 1'b0;
                    cmd_addr_d  = '0;
                    cmd_wdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and command register bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_read_q  <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_read_q  <= cmd_read_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
        end
    end

    assign bus.mem_read     = cmd_read_q;
    assign bus.mem_write    = cmd_write_q;
    assign bus.mem_address  = cmd_addr_q;
    assign bus.mem_wdata256 = cmd_wdata_q;
    assign bus.inst_resp    = inst_resp_c;
    assign bus.data_resp    = data_resp_c;
    assign bus.inst_rdata   = bus.mem_rdata;
    assign bus.data_rdata   = bus.mem_rdata;

    a_inst_drop: assert property (@(posedge clk) disable iff (rst)
        bus.inst_resp |=> !bus.inst_read)
        else $error("inst_read still high in the cycle after inst_resp");

    a_data_drop: assert property (@(posedge clk) disable iff (rst)
        bus.data_resp |=> !(bus.data_read || bus.data_write))
        else $error("data request still high in the cycle after data_resp");

    a_data_op: assert property (@(posedge clk) disable iff (rst)
        !(bus.data_read && bus.data_write))
        else $warning("data_read and data_write both high; serviced as a write");

    a_mem_op: assert property (@(posedge clk) disable iff (rst)
        !(bus.mem_read && bus.mem_write))
        else $error("mem_read and mem_write both high");

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed, table-driven bench for l2_port_arbiter.
module tb_l2_port_arbiter;
    import l2_port_arbiter_pkg::*;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned ADDR_W = 32;

    typedef struct {
        logic        rst;
        logic        ir;
        logic        dr;
        logic        dw;
        logic        mr;
        logic [31:0] ia;
        logic [31:0] da;
        logic        e_mr;
        logic        e_mw;
        logic [31:0] e_ma;
        logic        e_wd;
        logic        e_ir;
        logic        e_dr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [LINE_W-1:0] pat_aa;
    logic [LINE_W-1:0] pat_55;
    logic [LINE_W-1:0] pat_c3;

    vec_t vecs[$];

    always #5 clk = ~clk;

    l2_port_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

    l2_port_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic vec_t mk(logic r, logic ir, logic dr, logic dw, logic mr,
                                logic [31:0] ia, logic [31:0] da,
                                logic e_mr, logic e_mw, logic [31:0] e_ma,
                                logic e_wd, logic e_ir, logic e_dr);
        vec_t v;
        v.rst = r; v.ir = ir; v.dr = dr; v.dw = dw; v.mr = mr;
        v.ia = ia; v.da = da;
        v.e_mr = e_mr; v.e_mw = e_mw; v.e_ma = e_ma;
        v.e_wd = e_wd; v.e_ir = e_ir; v.e_dr = e_dr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic e_mr, input logic e_mw,
                               input logic [31:0] e_ma, input logic [LINE_W-1:0] e_wd,
                               input logic e_ir, input logic e_dr);
        chk({tag, " mem_read"},     LINE_W'(bus.mem_read),     LINE_W'(e_mr));
        chk({tag, " mem_write"},    LINE_W'(bus.mem_write),    LINE_W'(e_mw));
        chk({tag, " mem_address"},  LINE_W'(bus.mem_address),  LINE_W'(e_ma));
        chk({tag, " mem_wdata256"}, bus.mem_wdata256,          e_wd);
        chk({tag, " inst_resp"},    LINE_W'(bus.inst_resp),    LINE_W'(e_ir));
        chk({tag, " data_resp"},    LINE_W'(bus.data_resp),    LINE_W'(e_dr));
        if (e_ir) chk({tag, " inst_rdata"}, bus.inst_rdata, pat_aa);
        if (e_dr) chk({tag, " data_rdata"}, bus.data_rdata, pat_aa);
    endtask

    // Lone D writeback with address churn while busy and a chosen L2 latency.
    task automatic d_write_seq(input logic [31:0] addr, input logic [LINE_W-1:0] wd,
                               input int unsigned lat);
        @(posedge clk); #1;
        bus.data_write = 1'b1; bus.data_address = addr; bus.data_wdata = wd;
        @(negedge clk);
        chk_outputs("seq grant", 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0);
        for (int unsigned k = 0; k < lat; k++) begin
            @(posedge clk); #1;
            bus.data_address = $urandom;
            bus.data_wdata   = {8{$urandom}};
            @(negedge clk);
            chk_outputs("seq busy", 1'b0, 1'b1, addr, wd, 1'b0, 1'b0);
        end
        @(posedge clk); #1;
        bus.mem_resp = 1'b1;
        @(negedge clk);
        chk_outputs("seq resp", 1'b0, 1'b1, addr, wd, 1'b0, 1'b1);
        @(posedge clk); #1;
        bus.mem_resp = 1'b0; bus.data_write = 1'b0;
        @(negedge clk);
        chk_outputs("seq idle", 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        pat_aa = {32{8'hAA}};
        pat_55 = {32{8'h55}};
        pat_c3 = {32{8'hC3}};

        rst = 1'b1;
        bus.inst_read = 1'b0; bus.inst_address = '0;
        bus.data_read = 1'b0; bus.data_write = 1'b0;
        bus.data_address = '0; bus.data_wdata = pat_55;
        bus.mem_resp = 1'b0; bus.mem_rdata = pat_aa;

        // rst ir dr dw mr  ia  da | mr mw ma wd ir dr
        // Lone I read, L2 answers on the fifth busy cycle.
        vecs.push_back(mk(0,1,0,0,0, 32'h1000,0,        0,0,32'h0,   0,0,0));
        vecs.push_back(mk(0,1,0,0,0, 32'h1000,0,        1,0,32'h1000,0,0,0));
        vecs.push_back(mk(0,1,0,0,0, 32'h1000,0,        1,0,32'h1000,0,0,0));
        vecs.push_back(mk(0,1,0,0,0, 32'h1000,0,        1,0,32'h1000,0,0,0));
        vecs.push_back(mk(0,1,0,0,0, 32'h1000,0,        1,0,32'h1000,0,0,0));
        vecs.push_back(mk(0,1,0,0,1, 32'h1000,0,        1,0,32'h1000,0,1,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,               0,0,32'h0,   0,0,0));
        // Lone D write with address churn, then mem_resp while idle.
        vecs.push_back(mk(0,0,0,1,0, 0,32'h2020,        0,0,32'h0,   0,0,0));
        vecs.push_back(mk(0,0,0,1,0, 0,32'h2020,        0,1,32'h2020,1,0,0));
        vecs.push_back(mk(0,0,0,1,0, 0,32'h3030,        0,1,32'h2020,1,0,0));
        vecs.push_back(mk(0,0,0,1,1, 0,32'h3030,        0,1,32'h2020,1,0,1));
        vecs.push_back(mk(0,0,0,0,1, 0,0,               0,0,32'h0,   0,0,0));
        // D read interrupted by reset.
        vecs.push_back(mk(0,0,1,0,0, 0,32'h4000,        0,0,32'h0,   0,0,0));
        vecs.push_back(mk(0,0,1,0,0, 0,32'h4000,        1,0,32'h4000,0,0,0));
        vecs.push_back(mk(1,0,1,0,0, 0,32'h4000,        0,0,32'h0,   0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,               0,0,32'h0,   0,0,0));
        // Contention from reset: I first, then D.
        vecs.push_back(mk(0,1,1,0,0, 32'h1100,32'h2200, 0,0,32'h0,   0,0,0));
        vecs.push_back(mk(0,1,1,0,0, 32'h1100,32'h2200, 1,0,32'h1100,0,0,0));
        vecs.push_back(mk(0,1,1,0,1, 32'h1100,32'h2200, 1,0,32'h1100,0,1,0));
        vecs.push_back(mk(0,0,1,0,0, 0,32'h2200,        0,0,32'h0,   0,0,0));
        vecs.push_back(mk(0,1,1,0,0, 32'h1100,32'h2200, 1,0,32'h2200,0,0,0));
        vecs.push_back(mk(0,1,1,0,1, 32'h1100,32'h2200, 1,0,32'h2200,0,0,1));
        // I request dropped before grant; lone I sets last grant to I.
        vecs.push_back(mk(0,0,0,0,0, 0,0,               0,0,32'h0,   0,0,0));
        vecs.push_back(mk(0,1,0,0,0, 32'h1300,0,        0,0,32'h0,   0,0,0));
        vecs.push_back(mk(0,1,0,0,0, 32'h1300,0,        1,0,32'h1300,0,0,0));
        vecs.push_back(mk(0,1,0,0,1, 32'h1300,0,        1,0,32'h1300,0,1,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,               0,0,32'h0,   0,0,0));
        // Both together after an I grant: D wins, then the waiting I.
        vecs.push_back(mk(0,1,1,0,0, 32'h1400,32'h2400, 0,0,32'h0,   0,0,0));
        vecs.push_back(mk(0,1,1,0,0, 32'h1400,32'h2400, 1,0,32'h2400,0,0,0));
        vecs.push_back(mk(0,1,1,0,1, 32'h1400,32'h2400, 1,0,32'h2400,0,0,1));
        vecs.push_back(mk(0,1,0,0,0, 32'h1400,0,        0,0,32'h0,   0,0,0));
        vecs.push_back(mk(0,1,0,0,0, 32'h1400,0,        1,0,32'h1400,0,0,0));
        vecs.push_back(mk(0,1,0,0,1, 32'h1400,0,        1,0,32'h1400,0,1,0));
        vecs.push_back(mk(0,0,0,0,0, 0,0,               0,0,32'h0,   0,0,0));
        // Read and write together: serviced as one write.
        vecs.push_back(mk(0,0,1,1,0, 0,32'h5000,        0,0,32'h0,   0,0,0));
        vecs.push_back(mk(0,0,1,1,0, 0,32'h5000,        0,1,32'h5000,1,0,0));
        vecs.push_back(mk(0,0,1,1,1, 0,32'h5000,        0,1,32'h5000,1,0,1));
        vecs.push_back(mk(0,0,0,0,0, 0,0,               0,0,32'h0,   0,0,0));

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outputs("reset", 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            rst              = vecs[i].rst;
            bus.inst_read    = vecs[i].ir;
            bus.data_read    = vecs[i].dr;
            bus.data_write   = vecs[i].dw;
            bus.mem_resp     = vecs[i].mr;
            bus.inst_address = vecs[i].ia;
            bus.data_address = vecs[i].da;
            bus.data_wdata   = pat_55;
            @(negedge clk);
            chk_outputs($sformatf("row%0d", i), vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_ma,
                        vecs[i].e_wd ? pat_55 : '0, vecs[i].e_ir, vecs[i].e_dr);
        end

        d_write_seq(32'h0000_6000, pat_c3, 1);
        d_write_seq(32'h0000_7040, pat_55, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
